// File: rtl/bus_arbiter_mux.sv
// Registered bus arbiter and multiplexer.
// Picks one winning source per enabled cycle, using either fixed priority or
// round-robin. Registers the winner's data and index onto the shared bus,
// flags multi-request conflicts, and holds the last bus value when no source drives.
module bus_arbiter_mux #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5,
  parameter int RR_MODE = 0,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      bus_en,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [DATA_W-1:0]         bus_out,
  output logic [SEL_W-1:0]          bus_sel,
  output logic                      bus_valid,
  output logic                      conflict,
  output logic [CNT_W-1:0]          conflict_cnt
);

  // Registered state.
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  last_q, last_d;

  // Arbitration results.
  logic              any_req;
  logic              multi_req;
  logic              low_found;
  logic [SEL_W-1:0]  low_idx;
  logic              high_found;
  logic [SEL_W-1:0]  high_idx;
  logic [SEL_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_data;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign any_req   = |src_req;
  assign multi_req = (src_req & (src_req - NUM_SRC'(1))) != '0;

  // Priority search: lowest requester overall, and lowest requester above
  // last_grant (the round-robin candidate before wrapping to index 0).
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    low_found  = 1'b0;
    low_idx    = '0;
    high_found = 1'b0;
    high_idx   = '0;
    // Scanning downward means the last hit written is the lowest index.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        low_found = 1'b1;
        low_idx   = SEL_W'(i);
        if (SEL_W'(i) > last_q) begin
          high_found = 1'b1;
          high_idx   = SEL_W'(i);
        end
      end
    end
  end

  // Winner selection; the wrap case (no requester above last_grant) falls
  // back to the lowest requester, which may be last_grant itself.
  always_comb begin
    if (RR_MODE != 0 && high_found) begin
      win_idx = high_idx;
    end else begin
      win_idx = low_idx;
    end
  end

  // Data multiplexer for the winning source.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_idx == SEL_W'(i)) begin
        win_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: bus keeper by default, update only on an enabled grant.
  always_comb begin
    bus_d      = bus_q;
    sel_d      = sel_q;
    valid_d    = 1'b0;
    conflict_d = 1'b0;
    cnt_d      = cnt_q;
    last_d     = last_q;
    if (bus_en && any_req && low_found) begin
      bus_d      = win_data;
      sel_d      = win_idx;
      valid_d    = 1'b1;
      conflict_d = multi_req;
      last_d     = win_idx;
      if (multi_req && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      bus_q      <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      last_q     <= SEL_W'(NUM_SRC - 1);
    end else begin
      bus_q      <= bus_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  assign bus_out      = bus_q;
  assign bus_sel      = sel_q;
  assign bus_valid    = valid_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench for bus_arbiter_mux: three instances share the inputs
// (fixed priority, round-robin, fixed with a 2-bit conflict counter).
module tb_bus_arbiter_mux;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 24;
  localparam int SEL_W   = 5;

  logic                      clk;
  logic                      clear;
  logic                      bus_en;
  logic [NUM_SRC-1:0]        src_req;
  logic [NUM_SRC*DATA_W-1:0] src_data;

  logic [DATA_W-1:0] fix_out, rr_out, sat_out;
  logic [SEL_W-1:0]  fix_sel, rr_sel, sat_sel;
  logic              fix_valid, rr_valid, sat_valid;
  logic              fix_conf, rr_conf, sat_conf;
  logic [7:0]        fix_cnt, rr_cnt;
  logic [1:0]        sat_cnt;

  int n_pass  = 0;
  int n_total = 0;

  bus_arbiter_mux #(.RR_MODE(0)) u_fix (
    .clk(clk), .clear(clear), .bus_en(bus_en), .src_req(src_req), .src_data(src_data),
    .bus_out(fix_out), .bus_sel(fix_sel), .bus_valid(fix_valid),
    .conflict(fix_conf), .conflict_cnt(fix_cnt)
  );

  bus_arbiter_mux #(.RR_MODE(1)) u_rr (
    .clk(clk), .clear(clear), .bus_en(bus_en), .src_req(src_req), .src_data(src_data),
    .bus_out(rr_out), .bus_sel(rr_sel), .bus_valid(rr_valid),
    .conflict(rr_conf), .conflict_cnt(rr_cnt)
  );

  bus_arbiter_mux #(.RR_MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .clear(clear), .bus_en(bus_en), .src_req(src_req), .src_data(src_data),
    .bus_out(sat_out), .bus_sel(sat_sel), .bus_valid(sat_valid),
    .conflict(sat_conf), .conflict_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [23:0] req;
    logic [31:0] out;
    logic [4:0]  sel;
    logic        valid;
    logic        conf;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic en, input logic [23:0] req);
    bus_en  = en;
    src_req = req;
    @(posedge clk);
    #1;
  endtask

  // Hold clear low across edges with random requests, check all instances, release.
  task automatic do_reset();
    clear   = 1'b0;
    bus_en  = 1'b1;
    src_req = 24'($urandom);
    @(posedge clk);
    src_req = 24'($urandom);
    @(posedge clk);
    #1;
    check("rst_fix_out",   64'(fix_out),   64'h0);
    check("rst_fix_sel",   64'(fix_sel),   64'h0);
    check("rst_fix_valid", 64'(fix_valid), 64'h0);
    check("rst_fix_conf",  64'(fix_conf),  64'h0);
    check("rst_fix_cnt",   64'(fix_cnt),   64'h0);
    check("rst_rr_out",    64'(rr_out),    64'h0);
    check("rst_sat_cnt",   64'(sat_cnt),   64'h0);
    clear   = 1'b1;
    src_req = '0;
  endtask

  initial begin
    clear    = 1'b0;
    bus_en   = 1'b0;
    src_req  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i*DATA_W +: DATA_W] = 32'hA500_0000 | 32'(i);
    end
    src_data[0*DATA_W  +: DATA_W] = 32'h002C_3003;
    src_data[3*DATA_W  +: DATA_W] = 32'hAAAA_0003;
    src_data[7*DATA_W  +: DATA_W] = 32'h1234_5678;
    src_data[21*DATA_W +: DATA_W] = 32'h0000_0015;

    // Fixed-priority vectors, applied back to back from reset.
    vecs[0] = '{1'b1, 24'h000001, 32'h002C3003, 5'd0,  1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 24'h200008, 32'hAAAA0003, 5'd3,  1'b1, 1'b1, 8'd1};
    vecs[2] = '{1'b1, 24'h000080, 32'h12345678, 5'd7,  1'b1, 1'b0, 8'd1};
    vecs[3] = '{1'b1, 24'h000000, 32'h12345678, 5'd7,  1'b0, 1'b0, 8'd1};
    vecs[4] = '{1'b1, 24'h000000, 32'h12345678, 5'd7,  1'b0, 1'b0, 8'd1};
    vecs[5] = '{1'b1, 24'h000000, 32'h12345678, 5'd7,  1'b0, 1'b0, 8'd1};
    vecs[6] = '{1'b0, 24'hFFFFFF, 32'h12345678, 5'd7,  1'b0, 1'b0, 8'd1};
    vecs[7] = '{1'b1, 24'h800000, 32'hA5000017, 5'd23, 1'b1, 1'b0, 8'd1};
    vecs[8] = '{1'b1, 24'hC00000, 32'hA5000016, 5'd22, 1'b1, 1'b1, 8'd2};
    vecs[9] = '{1'b1, 24'hFFFFFF, 32'h002C3003, 5'd0,  1'b1, 1'b1, 8'd3};

    do_reset();
    for (int v = 0; v < 10; v++) begin
      step(vecs[v].en, vecs[v].req);
      check($sformatf("v%0d_out", v),   64'(fix_out),   64'(vecs[v].out));
      check($sformatf("v%0d_sel", v),   64'(fix_sel),   64'(vecs[v].sel));
      check($sformatf("v%0d_valid", v), 64'(fix_valid), 64'(vecs[v].valid));
      check($sformatf("v%0d_conf", v),  64'(fix_conf),  64'(vecs[v].conf));
      check($sformatf("v%0d_cnt", v),   64'(fix_cnt),   64'(vecs[v].cnt));
    end

    // Round-robin: first grant after reset searches from 0, then rotation.
    do_reset();
    step(1'b1, 24'hFFFFFF);
    check("rr_first_sel",  64'(rr_sel),  64'd0);
    check("rr_first_conf", 64'(rr_conf), 64'd1);
    step(1'b1, 24'h800024);
    check("rr_rot0_sel", 64'(rr_sel), 64'd2);
    check("rr_rot0_conf", 64'(rr_conf), 64'd1);
    step(1'b1, 24'h800024);
    check("rr_rot1_sel", 64'(rr_sel), 64'd5);
    check("rr_rot1_out", 64'(rr_out), 64'hA5000005);
    step(1'b1, 24'h800024);
    check("rr_rot2_sel", 64'(rr_sel), 64'd23);
    check("rr_rot2_conf", 64'(rr_conf), 64'd1);
    step(1'b1, 24'h800024);
    check("rr_rot3_sel", 64'(rr_sel), 64'd2);
    check("rr_rot3_cnt", 64'(rr_cnt), 64'd5);
    // Single requester equal to last_grant is still granted.
    step(1'b1, 24'h000004);
    check("rr_same_sel",   64'(rr_sel),   64'd2);
    check("rr_same_valid", 64'(rr_valid), 64'd1);
    check("rr_same_conf",  64'(rr_conf),  64'd0);
    // Disabled cycle holds last_grant: next grant continues after 2.
    step(1'b0, 24'h800024);
    check("rr_dis_valid", 64'(rr_valid), 64'd0);
    step(1'b1, 24'h800024);
    check("rr_after_dis_sel", 64'(rr_sel), 64'd5);

    // Saturating 2-bit counter.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 24'h000003);
      check($sformatf("sat_cnt%0d", c), 64'(sat_cnt), (c < 3) ? 64'(c + 1) : 64'd3);
    end
    check("sat_out_pre", 64'(sat_out), 64'h002C3003);

    // Mid-cycle clear acts without a clock edge.
    #2;
    clear = 1'b0;
    #1;
    check("midrst_cnt",   64'(sat_cnt),   64'd0);
    check("midrst_out",   64'(sat_out),   64'd0);
    check("midrst_valid", 64'(sat_valid), 64'd0);
    check("midrst_rr_sel", 64'(rr_sel),   64'd0);
    @(negedge clk);
    clear = 1'b1;
    // First RR grant after release searches from index 0 again.
    step(1'b1, 24'h100020);
    check("post_rr_sel",  64'(rr_sel),  64'd5);
    check("post_fix_sel", 64'(fix_sel), 64'd5);
    check("post_sat_cnt", 64'(sat_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
